golden_nonce_tx: RTL and testbench
==================================

Name: golden_nonce_tx

Overview:
- Downstream of the hash core. Captures each 32-bit golden nonce on its one-cycle match strobe into a small FIFO.
- Serializes each nonce as four UART 8N1 frames, byte0 = nonce[7:0] first, onto the host serial line.
- Runs entirely in hash_clk, so back-to-back strobes are never lost while a word is still being transmitted.

Parameters:
- CLKS_PER_BIT, 868, hash_clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, nonce FIFO entries; power of 2, minimum 2.

Ports:
- hash_clk  input  1  sole clock, all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- golden_nonce_in  input  32  nonce value, valid when golden_nonce_match=1.
- golden_nonce_match  input  1  one-cycle write strobe.
- uart_tx  output  1  serial line, idle high.
- tx_busy  output  1  high while the FIFO is non-empty or a frame is in flight.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  output  1  sticky, set when a strobe is dropped because the FIFO is full.

Behaviour:
- Reset:
  - While reset_n=0 at a clock edge: uart_tx=1, tx_busy=0, fifo_count=0, overflow=0.
  - FIFO pointers clear, FSM goes to IDLE, bit and byte counters clear.
  - Reset mid-frame aborts the frame: uart_tx is high on the next edge and the partial word is discarded.
- FIFO write:
  - golden_nonce_match=1 and not full: push golden_nonce_in.
  - Match while full: drop the value and set overflow; it stays set until reset.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - When full, a same-cycle pop frees the slot, so the write is accepted and overflow is not set.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into a 32-bit shift word, set byte_idx=0, go to START. Otherwise stay with uart_tx=1.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: uart_tx = current byte bit[bit_idx], LSB first, each for CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx<3: increment byte_idx, shift the word right by 8, go to START with no idle gap;
    - else go to IDLE.
- Timing:
  - Bit counter counts 0..CLKS_PER_BIT-1 and wraps.
  - One frame = 10*CLKS_PER_BIT cycles; one word = 40*CLKS_PER_BIT cycles.
  - IDLE costs exactly 1 cycle between words when the FIFO is non-empty.
  - Latency: a strobe sampled at edge N with the FIFO empty and FSM in IDLE gives the pop at edge N+1 and uart_tx=0 from edge N+2.
- tx_busy = (FSM != IDLE) | (fifo_count != 0), registered together with the state.
- Arithmetic:
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - The count uses one extra bit, so full means count==FIFO_DEPTH.
  - The nonce value is passed through unmodified; no offset correction happens here.

Decomposition:
- Shared package golden_nonce_tx_pkg holds:
  - the state enum (IDLE/START/DATA/STOP, 2 bits);
  - FRAME_BITS=10, DATA_BITS=8, BYTES_PER_WORD=4.
- One sub-module, nonce_fifo:
  - synchronous FIFO, parameter WIDTH=32 and DEPTH;
  - ports hash_clk, reset_n, wr_en, wr_data, rd_en, rd_data (first-word fall-through), count, full, empty.
  - Overflow detection stays in the top module.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single nonce: strobe 32'h12345678 at edge N.
  - uart_tx low at N+2.
  - Bytes decoded 78,56,34,12, each frame 40 cycles, total 160 cycles plus 1.
  - tx_busy drops the cycle after the last stop bit ends.
- Back-to-back: strobe 32'hA5A5A5A5 then 32'h0000FFFF on consecutive cycles.
  - Eight bytes A5 A5 A5 A5 FF FF 00 00.
  - Exactly one idle-high cycle between the two words.
  - overflow=0.
- Overflow: 6 strobes (values 1..6) in 6 consecutive cycles.
  - The first is popped immediately, the next four fill the FIFO, the 6th is dropped.
  - overflow=1 sticky; only 1..5 are transmitted.
- Simultaneous push/pop at full:
  - Fill 4 entries while a word is transmitting, then strobe on the IDLE pop cycle.
  - The write is accepted, fifo_count stays 4, overflow=0.
- Reset mid-frame:
  - Assert reset_n=0 for 1 cycle during DATA bit 3 of byte1 of 32'hDEADBEEF.
  - uart_tx=1 next edge; fifo_count=0, tx_busy=0, overflow=0.
  - No further frames are emitted until a new strobe arrives.
- Bit timing: strobe 32'h00000000.
  - Each start and data bit is low for exactly 4 cycles and the stop bit is high for 4 cycles, checked by a cycle-accurate monitor.

Source files
------------

// File: rtl/golden_nonce_tx_pkg.sv
// Shared types and framing constants for the golden-nonce UART transmitter.
package golden_nonce_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int FRAME_BITS     = 10;
  localparam int DATA_BITS      = 8;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop frees the slot for a same-cycle push.
module nonce_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     hash_clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge hash_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/golden_nonce_tx.sv
// Buffers golden nonces and sends each as four LSB-first 8N1 UART frames, byte0 first.
module golden_nonce_tx
  import golden_nonce_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          hash_clk,
  input  logic                          reset_n,
  input  logic [31:0]                   golden_nonce_in,
  input  logic                          golden_nonce_match,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int BYTE_W = $clog2(BYTES_PER_WORD);

  tx_state_e          state;
  logic [CNT_W-1:0]   clk_cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic [BYTE_W-1:0]  byte_idx;
  logic [31:0]        shift_word;
  logic [31:0]        fifo_rd_data;
  logic [DATA_BITS-1:0] cur_byte;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               bit_done;
  logic               last_byte;
  logic               line_bit;

  assign pop       = (state == IDLE) && !fifo_empty;
  assign bit_done  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_idx == BYTE_W'(BYTES_PER_WORD - 1));
  assign cur_byte  = shift_word[DATA_BITS-1:0];

  nonce_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .hash_clk (hash_clk),
    .reset_n  (reset_n),
    .wr_en    (golden_nonce_match),
    .wr_data  (golden_nonce_in),
    .rd_en    (pop),
    .rd_data  (fifo_rd_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Line level implied by the current state; registered one cycle later into uart_tx.
  always_comb begin
    line_bit = 1'b1;
    case (state)
      START:   line_bit = 1'b0;
      DATA:    line_bit = cur_byte[bit_idx];
      default: line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      uart_tx <= line_bit;
      tx_busy <= (state != IDLE) || (fifo_count != '0);
      if (golden_nonce_match && fifo_full && !pop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (pop) begin
            byte_idx <= '0;
            state    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            clk_cnt <= '0;
            if (bit_idx == BIT_W'(DATA_BITS - 1)) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            clk_cnt <= '0;
            if (!last_byte) begin
              byte_idx <= byte_idx + 1'b1;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge hash_clk) begin
    if (pop) shift_word <= fifo_rd_data;
    else if (state == STOP && bit_done && !last_byte) shift_word <= shift_word >> DATA_BITS;
  end

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Scoreboard bench: expected bytes are queued at each strobe and checked by a UART frame monitor.
module tb_golden_nonce_tx;

  localparam int CPB      = 4;
  localparam int DEPTH    = 4;
  localparam int WORD_CYC = 40 * CPB;

  typedef struct {
    logic [7:0] b;
    int         gap;
  } exp_t;

  logic        hash_clk = 1'b0;
  logic        reset_n  = 1'b0;
  logic [31:0] golden_nonce_in = '0;
  logic        golden_nonce_match = 1'b0;
  logic        uart_tx;
  logic        tx_busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t        sb[$];
  bit          mon_busy  = 0;
  int          scnt      = 0;
  logic [39:0] samp      = '0;
  int          gap       = 0;
  int          start_gap = 0;
  int          frames    = 0;

  golden_nonce_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .hash_clk           (hash_clk),
    .reset_n            (reset_n),
    .golden_nonce_in    (golden_nonce_in),
    .golden_nonce_match (golden_nonce_match),
    .uart_tx            (uart_tx),
    .tx_busy            (tx_busy),
    .fifo_count         (fifo_count),
    .overflow           (overflow)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] val, input int first_gap);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.b   = val[8*k +: 8];
      e.gap = (k == 0) ? first_gap : 0;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    golden_nonce_match = 1'b0;
    sb.delete();
    tick();
    tick();
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || mon_busy) && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", sb.size(), 0);
    repeat (3) tick();
    check("idle_tx_busy", tx_busy, 0);
  endtask

  // Frame monitor: every frame must occupy exactly 10 bit periods of CPB samples each.
  always @(negedge hash_clk) begin
    if (!reset_n) begin
      mon_busy = 0;
      scnt     = 0;
      gap      = 1000;
    end else if (!mon_busy) begin
      if (uart_tx === 1'b0) begin
        mon_busy  = 1;
        samp      = '0;
        scnt      = 1;
        start_gap = gap;
      end else begin
        gap++;
      end
    end else begin
      samp[scnt] = uart_tx;
      scnt++;
      if (scnt == 10 * CPB) begin
        logic [7:0]  d;
        logic [39:0] ideal;
        logic        lvl;
        for (int b = 0; b < 8; b++) d[b] = samp[4*(b+1)+1];
        for (int b = 0; b < 10; b++) begin
          lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
          ideal[4*b +: 4] = {4{lvl}};
        end
        check("frame_shape", samp, ideal);
        check("frame_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("byte", d, e.b);
          if (e.gap >= 0) check("idle_gap", start_gap, e.gap);
        end
        frames++;
        mon_busy = 0;
        gap      = 0;
      end
    end
  end

  initial begin
    int f0;
    int lows;

    // Reset state
    tick();
    do_reset();

    // Single nonce with latency and busy timing
    golden_nonce_in = 32'h12345678;
    golden_nonce_match = 1'b1;
    push_word(32'h12345678, -1);
    tick();                                   // edge N
    golden_nonce_match = 1'b0;
    check("single_cnt_N", fifo_count, 1);
    check("single_tx_N", uart_tx, 1);
    tick();                                   // edge N+1: pop
    check("single_cnt_N1", fifo_count, 0);
    check("single_tx_N1", uart_tx, 1);
    check("single_busy_N1", tx_busy, 1);
    tick();                                   // edge N+2: start bit
    check("single_tx_N2", uart_tx, 0);
    repeat (WORD_CYC - 1) tick();             // edge N+161
    check("single_busy_last", tx_busy, 1);
    tick();                                   // edge N+162
    check("single_busy_drop", tx_busy, 0);
    check("single_tx_idle", uart_tx, 1);
    wait_drain(100);

    // Back-to-back words with a single idle cycle between them
    do_reset();
    golden_nonce_in = 32'hA5A5A5A5;
    golden_nonce_match = 1'b1;
    push_word(32'hA5A5A5A5, -1);
    tick();
    golden_nonce_in = 32'h0000FFFF;
    push_word(32'h0000FFFF, 1);
    tick();
    golden_nonce_match = 1'b0;
    wait_drain(3 * WORD_CYC);
    check("b2b_overflow", overflow, 0);

    // Overflow: six strobes, sixth dropped
    do_reset();
    for (int v = 1; v <= 6; v++) begin
      golden_nonce_in = 32'(v);
      golden_nonce_match = 1'b1;
      if (v <= 5) push_word(32'(v), (v == 1) ? -1 : 1);
      tick();
    end
    golden_nonce_match = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_cnt_full", fifo_count, 4);
    wait_drain(6 * WORD_CYC);
    check("ovf_sticky", overflow, 1);

    // Push on the IDLE pop cycle while full
    do_reset();
    for (int k = 0; k < 5; k++) begin
      golden_nonce_in = 32'hC0DE0000 + 32'(k);
      golden_nonce_match = 1'b1;
      push_word(32'hC0DE0000 + 32'(k), (k == 0) ? -1 : 1);
      tick();                                 // edges N..N+4
    end
    golden_nonce_match = 1'b0;
    check("pp_cnt_full", fifo_count, 4);
    repeat (WORD_CYC - 3) tick();             // now after edge N+161
    golden_nonce_in = 32'hC0DE0005;
    golden_nonce_match = 1'b1;
    push_word(32'hC0DE0005, 1);
    tick();                                   // edge N+162: pop and push together
    golden_nonce_match = 1'b0;
    check("pp_cnt_kept", fifo_count, 4);
    check("pp_overflow", overflow, 0);
    wait_drain(7 * WORD_CYC);
    check("pp_overflow_end", overflow, 0);

    // Reset during DATA bit 3 of byte1
    do_reset();
    golden_nonce_in = 32'hDEADBEEF;
    golden_nonce_match = 1'b1;
    sb.push_back('{b: 8'hEF, gap: -1});
    tick();                                   // edge N
    golden_nonce_match = 1'b0;
    repeat (58) tick();                       // after edge N+58: bit 3 of byte1 on the line
    reset_n = 1'b0;
    tick();                                   // edge N+59
    reset_n = 1'b1;
    check("mid_uart_tx", uart_tx, 1);
    check("mid_fifo_count", fifo_count, 0);
    check("mid_tx_busy", tx_busy, 0);
    check("mid_overflow", overflow, 0);
    check("mid_first_byte", sb.size(), 0);
    f0 = frames;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    check("mid_line_quiet", lows, 0);
    check("mid_no_frames", frames - f0, 0);

    // Bit timing on an all-zero word
    golden_nonce_in = 32'h00000000;
    golden_nonce_match = 1'b1;
    push_word(32'h00000000, -1);
    tick();
    golden_nonce_match = 1'b0;
    wait_drain(2 * WORD_CYC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
